// File: rtl/alu_exec_seq.sv
// Sequences one ALU operation: latch request, load TMP, compute, present result with flags.
// Accept to result-valid is three edges; result is held in DONE until downstream ready, no new accept meanwhile.
module alu_exec_seq #(
  parameter int WIDTH = 8
) (
  input  logic             wclk,
  input  logic             wrstn,
  input  logic             wreq_valid,
  output logic             wreq_ready,
  input  logic [2:0]       bops,
  input  logic [WIDTH-1:0] bra,
  input  logic [WIDTH-1:0] brb,
  input  logic             wbus1,
  input  logic             wuse_carry,
  input  logic             wclf,
  output logic [WIDTH-1:0] balu_a,
  output logic [WIDTH-1:0] balu_b,
  output logic             walu_ci,
  output logic [2:0]       balu_op,
  input  logic [WIDTH-1:0] balu_c,
  input  logic             walu_co,
  input  logic             walu_eq,
  input  logic             walu_alo,
  input  logic             walu_z,
  output logic             wres_valid,
  input  logic             wres_ready,
  output logic [WIDTH-1:0] bres,
  output logic             wres_wr,
  output logic [3:0]       bflags
);

  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TMP  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             live_q;
  logic [WIDTH-1:0] a_lat_q, a_lat_d;
  logic [WIDTH-1:0] b_lat_q, b_lat_d;
  logic [2:0]       op_q, op_d;
  logic             uc_q, uc_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic             wr_q, wr_d;
  logic             accept;

  // live_q keeps ready low while reset is asserted and until the first edge after release
  assign wreq_ready = live_q && (state_q == S_IDLE);
  assign accept     = wreq_valid && wreq_ready;
  assign wres_valid = (state_q == S_DONE);
  assign balu_a     = alu_a_q;
  assign balu_b     = tmp_q;
  assign balu_op    = (state_q == S_CALC) ? op_q : 3'd0;
  assign walu_ci    = (state_q == S_CALC) && uc_q && flags_q[3];
  assign bres       = acc_q;
  assign wres_wr    = wr_q;
  assign bflags     = flags_q;

  always_comb begin
    state_d = state_q;
    a_lat_d = a_lat_q;
    b_lat_d = b_lat_q;
    op_d    = op_q;
    uc_d    = uc_q;
    tmp_d   = tmp_q;
    alu_a_d = alu_a_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        // Clearing here means an op accepted in the same cycle computes with C=0
        if (wclf) flags_d = 4'b0000;
        if (accept) begin
          a_lat_d = bra;
          b_lat_d = wbus1 ? WIDTH'(1) : brb;
          op_d    = bops;
          uc_d    = wuse_carry;
          state_d = S_TMP;
        end
      end
      S_TMP: begin
        tmp_d   = b_lat_q;
        alu_a_d = a_lat_q;
        state_d = S_CALC;
      end
      S_CALC: begin
        acc_d   = balu_c;
        flags_d = {walu_co, walu_alo, walu_eq, walu_z};
        wr_d    = (op_q != OP_CMP);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (wres_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      a_lat_q <= '0;
      b_lat_q <= '0;
      op_q    <= 3'd0;
      uc_q    <= 1'b0;
      tmp_q   <= '0;
      alu_a_q <= '0;
      acc_q   <= '0;
      flags_q <= 4'b0000;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      a_lat_q <= a_lat_d;
      b_lat_q <= b_lat_d;
      op_q    <= op_d;
      uc_q    <= uc_d;
      tmp_q   <= tmp_d;
      alu_a_q <= alu_a_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq with a behavioural ALU attached to its ALU-side ports.
module tb_alu_exec_seq;

  logic       wclk = 1'b0;
  logic       wrstn;
  logic       wreq_valid;
  logic       wreq_ready;
  logic [2:0] bops;
  logic [7:0] bra, brb;
  logic       wbus1, wuse_carry, wclf;
  logic [7:0] balu_a, balu_b;
  logic       walu_ci;
  logic [2:0] balu_op;
  logic [7:0] balu_c;
  logic       walu_co, walu_eq, walu_alo, walu_z;
  logic       wres_valid, wres_ready;
  logic [7:0] bres;
  logic       wres_wr;
  logic [3:0] bflags;

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;

  alu_exec_seq #(.WIDTH(8)) dut (
    .wclk(wclk), .wrstn(wrstn),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready),
    .bops(bops), .bra(bra), .brb(brb),
    .wbus1(wbus1), .wuse_carry(wuse_carry), .wclf(wclf),
    .balu_a(balu_a), .balu_b(balu_b), .walu_ci(walu_ci), .balu_op(balu_op),
    .balu_c(balu_c), .walu_co(walu_co), .walu_eq(walu_eq), .walu_alo(walu_alo), .walu_z(walu_z),
    .wres_valid(wres_valid), .wres_ready(wres_ready),
    .bres(bres), .wres_wr(wres_wr), .bflags(bflags)
  );

  // Behavioural ALU: shifts feed carry-in into the vacated bit and shift the lost bit into carry-out
  always_comb begin
    balu_c  = 8'h00;
    walu_co = 1'b0;
    case (balu_op)
      3'd0: {walu_co, balu_c} = {1'b0, balu_a} + {1'b0, balu_b} + {8'h00, walu_ci};
      3'd1: begin balu_c = {walu_ci, balu_a[7:1]}; walu_co = balu_a[0]; end
      3'd2: begin balu_c = {balu_a[6:0], walu_ci}; walu_co = balu_a[7]; end
      3'd3: balu_c = ~balu_a;
      3'd4: balu_c = balu_a & balu_b;
      3'd5: balu_c = balu_a | balu_b;
      3'd6: balu_c = balu_a ^ balu_b;
      default: balu_c = 8'h00;
    endcase
    walu_eq  = (balu_a == balu_b);
    walu_alo = (balu_a > balu_b);
    walu_z   = (balu_c == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic bus1, input logic uc, input logic clf,
                        input logic [7:0] exp_b, input logic exp_ci,
                        input logic [7:0] exp_res, input logic [3:0] exp_fl, input logic exp_wr);
    @(negedge wclk);
    chk({tag, ".req_ready"}, wreq_ready, 1);
    wreq_valid = 1'b1; bops = op; bra = a; brb = b;
    wbus1 = bus1; wuse_carry = uc; wclf = clf; wres_ready = 1'b1;
    @(posedge wclk); #1;
    // Scramble request fields after accept; they must have no effect
    wreq_valid = 1'b0; wclf = 1'b0;
    bops = ~op; bra = ~a; brb = ~b; wbus1 = ~bus1; wuse_carry = ~uc;
    @(negedge wclk);
    chk({tag, ".valid_tmp"}, wres_valid, 0);
    @(negedge wclk);
    chk({tag, ".valid_calc"}, wres_valid, 0);
    chk({tag, ".alu_op"}, balu_op, op);
    chk({tag, ".alu_a"}, balu_a, a);
    chk({tag, ".alu_b"}, balu_b, exp_b);
    chk({tag, ".alu_ci"}, walu_ci, exp_ci);
    @(negedge wclk);
    chk({tag, ".valid_done"}, wres_valid, 1);
    chk({tag, ".res"}, bres, exp_res);
    chk({tag, ".flags"}, bflags, exp_fl);
    chk({tag, ".wr"}, wres_wr, exp_wr);
    chk({tag, ".op_idle"}, balu_op, 0);
    chk({tag, ".ci_idle"}, walu_ci, 0);
    @(posedge wclk); #1;
  endtask

  initial begin
    wrstn = 1'b0; wreq_valid = 1'b0; bops = 3'd0; bra = 8'h00; brb = 8'h00;
    wbus1 = 1'b0; wuse_carry = 1'b0; wclf = 1'b0; wres_ready = 1'b0;
    repeat (2) @(negedge wclk);
    chk("rst.req_ready", wreq_ready, 0);
    chk("rst.res_valid", wres_valid, 0);
    chk("rst.bres", bres, 0);
    chk("rst.bflags", bflags, 0);
    chk("rst.wr", wres_wr, 0);
    chk("rst.alu_a", balu_a, 0);
    chk("rst.alu_b", balu_b, 0);
    chk("rst.alu_op", balu_op, 0);
    chk("rst.alu_ci", walu_ci, 0);
    wrstn = 1'b1;
    #1 chk("rst.ready_before_edge", wreq_ready, 0);

    //      tag        op    A      B     bus1  uc  clf  expB  ci  res    flags    wr
    run_op("add_ff01", 3'd0, 8'hFF, 8'h01, 0, 0, 0, 8'h01, 0, 8'h00, 4'b1101, 1);
    run_op("adc_c1",   3'd0, 8'h10, 8'h20, 0, 1, 0, 8'h20, 1, 8'h31, 4'b0000, 1);
    run_op("set_c",    3'd0, 8'hFF, 8'h01, 0, 0, 0, 8'h01, 0, 8'h00, 4'b1101, 1);
    run_op("add_noc",  3'd0, 8'h10, 8'h20, 0, 0, 0, 8'h20, 0, 8'h30, 4'b0000, 1);
    run_op("cmp_eq",   3'd7, 8'h42, 8'h42, 0, 0, 0, 8'h42, 0, 8'h00, 4'b0011, 0);
    run_op("shl_81",   3'd2, 8'h81, 8'h00, 0, 0, 0, 8'h00, 0, 8'h02, 4'b1100, 1);
    run_op("shr_81",   3'd1, 8'h81, 8'h00, 0, 0, 0, 8'h00, 0, 8'h40, 4'b1100, 1);
    run_op("shr_cin",  3'd1, 8'h80, 8'h00, 0, 1, 0, 8'h00, 1, 8'hC0, 4'b0100, 1);
    run_op("xor",      3'd6, 8'hF0, 8'hFF, 0, 0, 0, 8'hFF, 0, 8'h0F, 4'b0000, 1);
    run_op("bus1",     3'd0, 8'h05, 8'h77, 1, 0, 0, 8'h01, 0, 8'h06, 4'b0100, 1);

    // Back-pressure in DONE while a new request and wclf are presented
    @(negedge wclk);
    wreq_valid = 1'b1; bops = 3'd0; bra = 8'hFF; brb = 8'h01;
    wbus1 = 1'b0; wuse_carry = 1'b0; wclf = 1'b0; wres_ready = 1'b0;
    @(posedge wclk); #1;
    bops = 3'd6; bra = 8'h33; brb = 8'h44; wclf = 1'b1;
    repeat (2) @(negedge wclk);
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      chk("hold.valid", wres_valid, 1);
      chk("hold.res", bres, 8'h00);
      chk("hold.flags", bflags, 4'b1101);
      chk("hold.req_ready", wreq_ready, 0);
    end
    wres_ready = 1'b1; wreq_valid = 1'b0; wclf = 1'b0;
    @(posedge wclk); #1;
    @(negedge wclk);
    chk("hold.release_ready", wreq_ready, 1);
    chk("hold.release_valid", wres_valid, 0);
    chk("hold.no_accept", bres, 8'h00);

    // wclf alone in IDLE
    wclf = 1'b1;
    @(posedge wclk); #1;
    wclf = 1'b0;
    @(negedge wclk);
    chk("clf.idle", bflags, 4'b0000);

    run_op("set_c2",   3'd0, 8'hFF, 8'h01, 0, 0, 0, 8'h01, 0, 8'h00, 4'b1101, 1);
    run_op("clf_acc",  3'd0, 8'h10, 8'h20, 0, 1, 1, 8'h20, 0, 8'h30, 4'b0000, 1);
    run_op("set_c3",   3'd0, 8'hFF, 8'h01, 0, 0, 0, 8'h01, 0, 8'h00, 4'b1101, 1);

    // Reset asserted while in CALC
    @(negedge wclk);
    wreq_valid = 1'b1; bops = 3'd0; bra = 8'h10; brb = 8'h20; wuse_carry = 1'b0;
    @(posedge wclk); #1;
    wreq_valid = 1'b0;
    repeat (2) @(negedge wclk);
    chk("abort.in_calc_op", balu_a, 8'h10);
    #1 wrstn = 1'b0;
    #1;
    chk("abort.valid", wres_valid, 0);
    chk("abort.res", bres, 0);
    chk("abort.flags", bflags, 0);
    chk("abort.alu_a", balu_a, 0);
    chk("abort.alu_b", balu_b, 0);
    chk("abort.alu_op", balu_op, 0);
    chk("abort.req_ready", wreq_ready, 0);
    @(negedge wclk);
    wrstn = 1'b1;
    run_op("post_rst", 3'd0, 8'h05, 8'h03, 0, 0, 0, 8'h03, 0, 8'h08, 4'b0100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
